// File: rtl/serial_digit_alu_if.sv
// serial_digit_alu_if
//   Request/result bundle between a controller (master) and the digit-serial ALU (slave).
//
//   Handshake: the master raises start with cmd/len/sign_ext/word1/word2/preinit_result
//   valid in the same cycle. The request is taken on that clock edge only while busy=0
//   (ALU idle, or in its one-cycle done state); while busy=1 start is ignored. done pulses
//   for exactly one cycle once the last digit has been written. result and carry_out are
//   then stable until the next accepted start.
//
//   Ports (master view):
//     start, cmd[2:0], len[LEN_W-1:0], sign_ext, word1[W-1:0], word2[W-1:0],
//     preinit_result[W-1:0]                          -> to ALU
//     busy, done, result[W-1:0], carry_out, state_dbg[1:0]  <- from ALU
//   state_dbg exposes the ALU control state (0 idle, 1 run, 2 done).
interface serial_digit_alu_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 8
);
    localparam int W     = DIGIT_W * NUM_DIGITS;
    localparam int LEN_W = $clog2(NUM_DIGITS);

    logic             start;
    logic [2:0]       cmd;
    logic [LEN_W-1:0] len;
    logic             sign_ext;
    logic [W-1:0]     word1;
    logic [W-1:0]     word2;
    logic [W-1:0]     preinit_result;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             carry_out;
    logic [1:0]       state_dbg;

    modport master (
        output start, cmd, len, sign_ext, word1, word2, preinit_result,
        input  busy, done, result, carry_out, state_dbg
    );

    modport slave (
        input  start, cmd, len, sign_ext, word1, word2, preinit_result,
        output busy, done, result, carry_out, state_dbg
    );
endinterface

// File: rtl/serial_digit_alu.sv
// serial_digit_alu
//   Digit-serial ALU: applies one DIGIT_W-bit ALU step per clock across the digits of a
//   word, passing a carry from digit to digit. ADD/SUB may run past the operand length
//   (sign/zero extension of word2) until the carry stops changing the result.
//
//   Ports:
//     clk    - clock, all logic on posedge
//     rst_n  - synchronous active-low reset
//     bus    - serial_digit_alu_if.slave (request, result and handshake signals)
module serial_digit_alu #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_digit_alu_if.slave bus
);
    localparam int W     = DIGIT_W * NUM_DIGITS;
    localparam int LEN_W = $clog2(NUM_DIGITS);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(NUM_DIGITS - 1);

    localparam logic [2:0] CMD_ADD   = 3'd0;
    localparam logic [2:0] CMD_SUB   = 3'd1;
    localparam logic [2:0] CMD_AND   = 3'd2;
    localparam logic [2:0] CMD_OR    = 3'd3;
    localparam logic [2:0] CMD_XOR   = 3'd4;
    localparam logic [2:0] CMD_LSHFT = 3'd5;
    localparam logic [2:0] CMD_RSHFT = 3'd6;
    localparam logic [2:0] CMD_ASHFT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sign_ext_q, sign_ext_d;
    logic [W-1:0]     word1_q, word1_d;
    logic [W-1:0]     word2_q, word2_d;
    logic [W-1:0]     result_q, result_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;

    logic               accept;
    logic               reverse;
    logic               fill_bit;
    logic               eb;
    logic               stop;
    logic               dig_c;
    logic [DIGIT_W-1:0] d1, d2, dig_r;
    logic [DIGIT_W:0]   sum;

    // Requests are taken whenever the unit is not running, including the done cycle.
    assign accept = bus.start && (state_q != ST_RUN);

    // ---------------- state register (and datapath flops) ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            sign_ext_q  <= 1'b0;
            word1_q     <= '0;
            word2_q     <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            sign_ext_q  <= sign_ext_d;
            word1_q     <= word1_d;
            word2_q     <= word2_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
        end
    end

    // ---------------- digit datapath ----------------
    always_comb begin
        reverse  = (cmd_q == CMD_RSHFT) || (cmd_q == CMD_ASHFT);
        d1       = word1_q[idx_q*DIGIT_W +: DIGIT_W];
        // word2 digits above len are replaced by its sign (or zero) fill.
        fill_bit = sign_ext_q & word2_q[len_q*DIGIT_W + DIGIT_W - 1];
        d2       = (idx_q > len_q) ? {DIGIT_W{fill_bit}} : word2_q[idx_q*DIGIT_W +: DIGIT_W];
        // For SUB the B operand is inverted, so its fill is too.
        eb       = fill_bit ^ (cmd_q == CMD_SUB);

        sum   = '0;
        dig_r = '0;
        dig_c = 1'b0;
        case (cmd_q)
            CMD_ADD: begin
                sum   = {1'b0, d1} + {1'b0, d2} + {{DIGIT_W{1'b0}}, carry_q};
                dig_r = sum[DIGIT_W-1:0];
                dig_c = sum[DIGIT_W];
            end
            CMD_SUB: begin
                sum   = {1'b0, d1} + {1'b0, ~d2} + {{DIGIT_W{1'b0}}, carry_q};
                dig_r = sum[DIGIT_W-1:0];
                dig_c = sum[DIGIT_W];
            end
            CMD_AND:   dig_r = d1 & d2;
            CMD_OR:    dig_r = d1 | d2;
            CMD_XOR:   dig_r = d1 ^ d2;
            CMD_LSHFT: begin
                dig_r = {d1[DIGIT_W-2:0], carry_q};
                dig_c = d1[DIGIT_W-1];
            end
            default: begin
                dig_r = {carry_q, d1[DIGIT_W-1:1]};
                dig_c = d1[0];
            end
        endcase

        // Arithmetic past len keeps going only while the next digit would still change.
        if (reverse) begin
            stop = (idx_q == '0);
        end else if ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) begin
            stop = (idx_q == LAST_IDX) || ((idx_q >= len_q) && (dig_c == eb));
        end else begin
            stop = (idx_q == len_q) || (idx_q == LAST_IDX);
        end

        cmd_d       = cmd_q;
        len_d       = len_q;
        sign_ext_d  = sign_ext_q;
        word1_d     = word1_q;
        word2_d     = word2_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;

        if (accept) begin
            cmd_d      = bus.cmd;
            len_d      = bus.len;
            sign_ext_d = bus.sign_ext;
            word1_d    = bus.word1;
            word2_d    = bus.word2;
            result_d   = bus.preinit_result;
            idx_d      = ((bus.cmd == CMD_RSHFT) || (bus.cmd == CMD_ASHFT)) ? bus.len : '0;
            case (bus.cmd)
                CMD_SUB:   carry_d = 1'b1;
                CMD_ASHFT: carry_d = bus.word1[bus.len*DIGIT_W + DIGIT_W - 1];
                default:   carry_d = 1'b0;
            endcase
        end else if (state_q == ST_RUN) begin
            result_d[idx_q*DIGIT_W +: DIGIT_W] = dig_r;
            carry_d = dig_c;
            if (stop) begin
                carry_out_d = dig_c;
            end else begin
                idx_d = reverse ? (idx_q - 1'b1) : (idx_q + 1'b1);
            end
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (stop)   state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.busy      = (state_q == ST_RUN);
        bus.done      = (state_q == ST_DONE);
        bus.result    = result_q;
        bus.carry_out = carry_out_q;
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_serial_digit_alu.sv
// tb_serial_digit_alu
//   Directed bench for serial_digit_alu (DIGIT_W=4, NUM_DIGITS=8). Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_serial_digit_alu;
    localparam int W = 32;

    localparam logic [2:0] ADD   = 3'd0;
    localparam logic [2:0] SUB   = 3'd1;
    localparam logic [2:0] AND_C = 3'd2;
    localparam logic [2:0] OR_C  = 3'd3;
    localparam logic [2:0] XOR_C = 3'd4;
    localparam logic [2:0] LSH   = 3'd5;
    localparam logic [2:0] RSH   = 3'd6;
    localparam logic [2:0] ASH   = 3'd7;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    logic [W-1:0] snap1;

    serial_digit_alu_if #(.DIGIT_W(4), .NUM_DIGITS(8)) bus ();

    serial_digit_alu #(.DIGIT_W(4), .NUM_DIGITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called on a falling edge; returns on the falling edge after the accepting clock.
    task automatic begin_op(input logic [2:0] c, input logic [2:0] l, input logic se,
                            input logic [W-1:0] w1, input logic [W-1:0] w2,
                            input logic [W-1:0] pre);
        bus.cmd            = c;
        bus.len            = l;
        bus.sign_ext       = se;
        bus.word1          = w1;
        bus.word2          = w2;
        bus.preinit_result = pre;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start          = 1'b0;
    endtask

    // Counts run cycles until busy drops; returns on the falling edge of the done cycle.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            if (n == 1) snap1 = bus.result;
        end
        check("no_timeout", W'(n < 40), W'(1));
        check("done_pulse", W'(bus.done), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [2:0] l,
                          input logic se, input logic [W-1:0] w1, input logic [W-1:0] w2,
                          input logic [W-1:0] pre, input logic [W-1:0] exp_res,
                          input logic exp_co, input int exp_cyc);
        begin_op(c, l, se, w1, w2, pre);
        wait_done(cyc);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_carry"}, W'(bus.carry_out), W'(exp_co));
        check({tag, "_cycles"}, W'(cyc), W'(exp_cyc));
        @(negedge clk);
        check({tag, "_done_low"}, W'(bus.done), W'(0));
        check({tag, "_hold"}, bus.result, exp_res);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks             = 0;
        failures           = 0;
        snap1              = '0;
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.cmd            = '0;
        bus.len            = '0;
        bus.sign_ext       = 1'b0;
        bus.word1          = '0;
        bus.word2          = '0;
        bus.preinit_result = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_result", bus.result, W'(0));
        check("rst_carry", W'(bus.carry_out), W'(0));
        check("rst_state", W'(bus.state_dbg), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_full", ADD, 3'd7, 1'b0, 32'h0EFF_FFFF, 32'h0000_0001, 32'hF000_0000,
               32'h0F00_0000, 1'b0, 8);
        run_op("add_ext", ADD, 3'd0, 1'b0, 32'h0000_0AFF, 32'h0000_0001, 32'h0000_0000,
               32'h0000_0B00, 1'b0, 3);
        run_op("add_sext", ADD, 3'd1, 1'b1, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_FFFF,
               32'h0000_FFFE, 1'b1, 2);
        run_op("sub", SUB, 3'd7, 1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000,
               32'hFFFF_FFFF, 1'b0, 8);
        run_op("xor", XOR_C, 3'd3, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000,
               32'h0000_A987, 1'b0, 4);
        run_op("rshft", RSH, 3'd7, 1'b0, 32'h0600_0000, 32'h0000_0000, 32'hFFFF_FFFF,
               32'h0300_0000, 1'b0, 8);
        // Top digit is written first in a right shift.
        check("rshft_first_digit", snap1, 32'h0FFF_FFFF);
        run_op("ashft", ASH, 3'd7, 1'b0, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000,
               32'hC000_0000, 1'b1, 8);
        run_op("lshft", LSH, 3'd7, 1'b0, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000,
               32'h0000_0002, 1'b1, 8);

        // Reset in the middle of a run.
        begin_op(ADD, 3'd7, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h5555_5555);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", W'(bus.busy), W'(0));
        check("midrst_done", W'(bus.done), W'(0));
        check("midrst_result", bus.result, W'(0));
        check("midrst_carry", W'(bus.carry_out), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // start while busy is ignored.
        begin_op(XOR_C, 3'd7, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000);
        bus.cmd            = ADD;
        bus.len            = 3'd0;
        bus.word1          = 32'h0000_0000;
        bus.word2          = 32'h0000_0000;
        bus.preinit_result = 32'h9999_9999;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        check("busy_start_result", bus.result, 32'hEDCB_A987);
        check("busy_start_cycles", W'(cyc), W'(7));
        @(negedge clk);
        check("busy_start_idle", W'(bus.busy), W'(0));

        // Back-to-back: new start in the done cycle.
        begin_op(AND_C, 3'd1, 1'b0, 32'hFFFF_FF3C, 32'h0000_00F5, 32'hAAAA_AAAA);
        wait_done(cyc);
        check("b2b_and_result", bus.result, 32'hAAAA_AA34);
        check("b2b_and_cycles", W'(cyc), W'(2));
        check("b2b_gap_busy", W'(bus.busy), W'(0));
        begin_op(OR_C, 3'd2, 1'b0, 32'h0000_0120, 32'h0000_0403, 32'h0000_0000);
        check("b2b_accept_busy", W'(bus.busy), W'(1));
        check("b2b_accept_done", W'(bus.done), W'(0));
        wait_done(cyc);
        check("b2b_or_result", bus.result, 32'h0000_0523);
        check("b2b_or_cycles", W'(cyc), W'(3));
        @(negedge clk);
        check("b2b_done_low", W'(bus.done), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
